// File: rtl/baud_pkg.sv
// baud_pkg: shared constants and increment calculator for the fractional baud generator
package baud_pkg;
  localparam int ACC_W_DEF = 16;
  localparam int OS_DEF = 8;
  localparam int OS_W = $clog2(OS_DEF);
  localparam longint SYS_CLK_HZ = 27_000_000;
  // round(baud*os*2^acc_w/clk_hz) in 64-bit integer arithmetic
  function automatic int unsigned calc_inc(longint clk_hz, longint baud, longint os, int acc_w);
    return int'((baud * os * (longint'(1) << acc_w) + clk_hz / 2) / clk_hz);
  endfunction
  localparam int unsigned INC_9600 = calc_inc(SYS_CLK_HZ, 9600, OS_DEF, ACC_W_DEF);
  localparam int unsigned INC_115200 = calc_inc(SYS_CLK_HZ, 115200, OS_DEF, ACC_W_DEF);
  localparam int unsigned INC_921600 = calc_inc(SYS_CLK_HZ, 921600, OS_DEF, ACC_W_DEF);
endpackage

// File: rtl/baud_gen_frac_os_divider.sv
// os_divider: divides accumulator carries down to a bit-rate tick and tracks oversample phase
// Ports: sys_clk/sys_rst_n clock and async active-low reset; enable, carry, resync in;
//        baud_tick (registered, one cycle) and phase (oversample count) out.
module os_divider
  import baud_pkg::*;
#(
  parameter int OVERSAMPLE = OS_DEF
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          enable,
  input  logic                          carry,
  input  logic                          resync,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] phase
);
  localparam int PW = $clog2(OVERSAMPLE);
  logic [PW-1:0] cnt_q, cnt_d;
  logic baud_q, baud_d, tick;
  // OVERSAMPLE is a power of two, so the plain increment wraps OVERSAMPLE-1 -> 0
  always_comb begin
    tick = carry & enable;
    cnt_d = resync ? PW'(OVERSAMPLE / 2) : tick ? cnt_q + PW'(1) : cnt_q;
    baud_d = tick & ~resync & (cnt_q == PW'(OVERSAMPLE - 1));
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      baud_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      baud_q <= baud_d;
    end
  end
  assign baud_tick = baud_q;
  assign phase = cnt_q;
endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N oversample and bit-rate tick generator
// Ports: sys_clk/sys_rst_n clock and async active-low reset; enable freezes state when low;
//        inc_in/inc_load program the increment; resync re-centres phase on an RX start edge;
//        os_tick, baud_tick (registered, one cycle) and phase (oversample count) out.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_W_DEF,
  parameter int OVERSAMPLE = OS_DEF,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_INC = ACC_WIDTH'(2237)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          enable,
  input  logic [ACC_WIDTH-1:0]          inc_in,
  input  logic                          inc_load,
  input  logic                          resync,
  output logic                          os_tick,
  output logic                          baud_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] phase
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d, inc_q, inc_d;
  logic [ACC_WIDTH:0] sum;
  logic carry, os_tick_q, os_tick_d;
  // the carry always comes from the increment in use before any same-cycle inc_load
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, inc_q};
    carry = sum[ACC_WIDTH] & enable;
    acc_d = resync ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : enable ? sum[ACC_WIDTH-1:0] : acc_q;
    inc_d = inc_load ? inc_in : inc_q;
    os_tick_d = carry & ~resync;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_q <= '0;
      inc_q <= DEFAULT_INC;
      os_tick_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      os_tick_q <= os_tick_d;
    end
  end
  assign os_tick = os_tick_q;
  os_divider #(.OVERSAMPLE(OVERSAMPLE)) u_div (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable   (enable),
    .carry    (carry),
    .resync   (resync),
    .baud_tick(baud_tick),
    .phase    (phase)
  );
endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: self-checking bench for baud_gen_frac against a running-total phase model
`timescale 1ns/100ps
module tb_baud_gen_frac;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0, enable = 1'b0, inc_load = 1'b0, resync = 1'b0;
  logic [15:0] inc_in = '0;
  logic os_tick, baud_tick;
  logic [2:0] phase;
  int n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;

  always #18.5 sys_clk = ~sys_clk;

  baud_gen_frac dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .enable   (enable),
    .inc_in   (inc_in),
    .inc_load (inc_load),
    .resync   (resync),
    .os_tick  (os_tick),
    .baud_tick(baud_tick),
    .phase    (phase)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_pos is the unbounded total of all increments added since the last
  // reset/resync base; an os tick happens whenever that total crosses a multiple
  // of 2^16. m_ticks counts os ticks, so phase is m_ticks mod 8 and a baud tick
  // is every 8th tick.
  longint m_pos, m_inc;
  int m_ticks;
  logic e_os, e_baud;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_pos <= 0;
      m_inc <= 2237;
      m_ticks <= 0;
      e_os <= 1'b0;
      e_baud <= 1'b0;
    end else begin
      if (resync) begin
        m_pos <= 32768;
        m_ticks <= 4;
        e_os <= 1'b0;
        e_baud <= 1'b0;
      end else if (enable && ((m_pos + m_inc) / 65536 > m_pos / 65536)) begin
        m_pos <= m_pos + m_inc;
        m_ticks <= m_ticks + 1;
        e_os <= 1'b1;
        e_baud <= ((m_ticks + 1) % 8 == 0);
      end else begin
        if (enable) m_pos <= m_pos + m_inc;
        e_os <= 1'b0;
        e_baud <= 1'b0;
      end
      if (inc_load) m_inc <= longint'(inc_in);
    end
  end

  always @(negedge sys_clk) begin
    if (chk_on) begin
      check("model_os_tick", os_tick, e_os);
      check("model_baud_tick", baud_tick, e_baud);
      check("model_phase", phase, m_ticks % 8);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_os(input int lim, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!os_tick && n < lim);
    check("os_tick_arrives", os_tick, 1);
  endtask

  task automatic wait_baud(input int lim, output int n);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!baud_tick && n < lim);
    check("baud_tick_arrives", baud_tick, 1);
  endtask

  initial begin
    int n, cnt_os, cnt_baud, first;
    cyc(2);
    chk_on = 1'b1;
    check("rst_os_tick", os_tick, 0);
    check("rst_baud_tick", baud_tick, 0);
    check("rst_phase", phase, 0);
    // test 1: inc 16384 -> os every 4, baud every 32
    sys_rst_n = 1'b1;
    inc_in = 16'd16384;
    inc_load = 1'b1;
    cyc(1);
    inc_load = 1'b0;
    enable = 1'b1;
    wait_os(20, n);
    check("t1_first_os", n, 4);
    for (int i = 0; i < 3; i++) begin
      wait_os(20, n);
      check("t1_os_spacing", n, 4);
    end
    wait_baud(100, n);
    check("t1_first_baud", n, 16);
    check("t1_baud_with_os", os_tick, 1);
    check("t1_baud_phase", phase, 0);
    wait_baud(100, n);
    check("t1_baud_spacing", n, 32);
    // test 3: resync mid-run
    cyc(5);
    resync = 1'b1;
    cyc(1);
    resync = 1'b0;
    check("t3_resync_os", os_tick, 0);
    check("t3_resync_baud", baud_tick, 0);
    check("t3_resync_phase", phase, 4);
    wait_os(20, n);
    check("t3_first_os", n + 1, 3);
    wait_baud(100, n);
    check("t3_first_baud", n + 3, 15);
    // test 4: freeze for 50 cycles
    wait_os(20, n);
    enable = 1'b0;
    cnt_os = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      cnt_os += int'(os_tick) + int'(baud_tick);
    end
    check("t4_frozen_ticks", cnt_os, 0);
    enable = 1'b1;
    wait_os(100, n);
    check("t4_resume_gap", n + 50, 54);
    // test 5: inc_load coincident with a carry
    cyc(3);
    inc_in = 16'd8192;
    inc_load = 1'b1;
    cyc(1);
    inc_load = 1'b0;
    check("t5_old_carry_tick", os_tick, 1);
    for (int i = 0; i < 2; i++) begin
      wait_os(40, n);
      check("t5_os_spacing", n, 8);
    end
    wait_baud(200, n);
    // test 6: inc 0 stops ticks, then async reset mid-cycle
    inc_in = 16'd0;
    inc_load = 1'b1;
    cyc(1);
    inc_load = 1'b0;
    cnt_os = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge sys_clk);
      cnt_os += int'(os_tick) + int'(baud_tick);
    end
    check("t6_no_ticks", cnt_os, 0);
    #5 sys_rst_n = 1'b0;
    #1;
    check("t6_async_os", os_tick, 0);
    check("t6_async_baud", baud_tick, 0);
    check("t6_async_phase", phase, 0);
    cyc(2);
    sys_rst_n = 1'b1;
    // test 2 over 27000 cycles at DEFAULT_INC from reset
    cnt_os = 0;
    cnt_baud = 0;
    first = 0;
    for (int i = 1; i <= 27000; i++) begin
      @(negedge sys_clk);
      if (os_tick && first == 0) first = i;
      cnt_os += int'(os_tick);
      cnt_baud += int'(baud_tick);
    end
    check("t6_first_default_os", first, 30);
    check("t2_os_count", cnt_os, 921);
    check("t2_baud_count", cnt_baud, 115);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
